// File: rtl/compressor_result_serializer.sv
// Parallel-to-serial readback stage: captures WIDTH compressor column outputs and
// streams them LSB first over valid/ready. Optional trailing even-parity bit: SERIALIZER_PARITY_EN.
module compressor_result_serializer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] dst,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 2);
`ifdef SERIALIZER_PARITY_EN
  localparam int unsigned SH_W = WIDTH + 1;
`else
  localparam int unsigned SH_W = WIDTH;
`endif
  localparam int unsigned LAST = SH_W - 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_next_state;
  logic [SH_W-1:0]  r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [SH_W-1:0]  w_capture;
  logic             w_xfer;
  logic             w_last;

`ifdef SERIALIZER_PARITY_EN
  assign w_capture = {^dst, dst};
`else
  assign w_capture = dst;
`endif

  assign w_xfer = (r_state == S_SHIFT) && sout_ready;
  assign w_last = (r_cnt == CNT_W'(LAST));

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (load) w_next_state = S_SHIFT;
      S_SHIFT: if (w_xfer && w_last) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Shift register empties to zero by frame end, so sout idles low without gating
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_xfer && w_last;
      if ((r_state == S_IDLE) && load) begin
        r_shreg <= w_capture;
        r_cnt   <= '0;
      end else if (w_xfer) begin
        r_shreg <= {1'b0, r_shreg[SH_W-1:1]};
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign sout       = r_shreg[0];
  assign sout_valid = (r_state == S_SHIFT);
  assign busy       = (r_state == S_SHIFT);
  assign done       = r_done;

endmodule

// File: tb/tb_compressor_result_serializer.sv
// Directed self-checking bench for compressor_result_serializer (WIDTH=32).
`timescale 1ns/1ps
module tb_compressor_result_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME = 33;
`else
  localparam int FRAME = 32;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] dst;
  logic        sout;
  logic        sout_valid;
  logic        sout_ready;
  logic        busy;
  logic        done;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  compressor_result_serializer #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .dst        (dst),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] d);
    dst  = d;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Walks one frame; returns in the done cycle, or right after an injected reset
  task automatic stream(input logic [31:0] d, input bit stall, input int busy_load_bit,
                        input int abort_bit);
    logic [FRAME-1:0] e;
    int cyc;
`ifdef SERIALIZER_PARITY_EN
    e = {^d, d};
`else
    e = d;
`endif
    cyc = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (stall) begin
        sout_ready = 1'b0;
        chk("stall_valid", sout_valid, 1'b1);
        chk("stall_sout", sout, e[i]);
        tick();
        cyc++;
      end
      if (i == abort_bit) begin
        rst        = 1'b1;
        sout_ready = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", sout_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        tick();
        chk("abort_done2", done, 1'b0);
        chk("abort_valid2", sout_valid, 1'b0);
        return;
      end
      sout_ready = 1'b1;
      if (i == busy_load_bit) begin
        load = 1'b1;
        dst  = 32'hFFFF_FFFF;
      end
      chk("bit_valid", sout_valid, 1'b1);
      chk("bit_busy", busy, 1'b1);
      chk("bit_sout", sout, e[i]);
      chk("bit_nodone", done, 1'b0);
      tick();
      cyc++;
      load = 1'b0;
    end
    chk("end_done", done, 1'b1);
    chk("end_valid", sout_valid, 1'b0);
    chk("end_busy", busy, 1'b0);
    if (stall) begin
      n_total++;
      assert (cyc == 2 * FRAME) n_pass++;
      else begin
        n_fail++;
        $error("FAIL stall_cycles: observed %0d expected %0d", cyc, 2 * FRAME);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    load       = 1'b1;
    dst        = 32'h1234_5678;
    sout_ready = 1'b1;

    // Reset held with load asserted: nothing starts
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_valid", sout_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_sout", sout, 1'b0);
    end
    rst  = 1'b0;
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_valid", sout_valid, 1'b0);
      chk("post_rst_busy", busy, 1'b0);
    end

    // Basic frame; first bits LSB first are 1,0,0,0,0,0,0,1,1,1,1,1
    start(32'hA5C3_0F81);
    chk("basic_b0", sout, 1'b1);
    stream(32'hA5C3_0F81, 1'b0, -1, -1);
    tick();
    chk("basic_done_once", done, 1'b0);
    chk("basic_idle_sout", sout, 1'b0);

    // Backpressure on every other cycle
    start(32'h3C96_E12B);
    stream(32'h3C96_E12B, 1'b1, -1, -1);
    tick();
    chk("bp_done_once", done, 1'b0);

    // Load while busy is ignored
    start(32'h0000_0000);
    stream(32'h0000_0000, 1'b0, 10, -1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("lwb_no_frame_valid", sout_valid, 1'b0);
      chk("lwb_no_frame_busy", busy, 1'b0);
    end

    // Back-to-back: load in the done cycle
    start(32'h8000_00F0);
    stream(32'h8000_00F0, 1'b0, -1, -1);
    start(32'h0000_0001);
    chk("b2b_valid", sout_valid, 1'b1);
    chk("b2b_sout", sout, 1'b1);
    stream(32'h0000_0001, 1'b0, -1, -1);
    tick();
    chk("b2b_done_once", done, 1'b0);

    // Reset mid-frame at bit 17, then a clean frame
    start(32'hDEAD_BEEF);
    stream(32'hDEAD_BEEF, 1'b0, -1, 17);
    start(32'h0F0F_1234);
    stream(32'h0F0F_1234, 1'b0, -1, -1);
    tick();
    chk("final_done_once", done, 1'b0);
    chk("final_valid", sout_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
